// File: rtl/program_loader_pkg.sv
// Shared definitions for the framed byte-stream program loader.
//   ADDR_W_DEF / SYNC_BYTE_DEF / TIMEOUT_CYC_DEF : default parameters
//   HDR_* : byte positions inside the 4-byte header (ADDR lo,hi, COUNT lo,hi)
//   WORD_LAST : position of the last (most significant) byte of a data word
//   state_e : loader FSM states
package program_loader_pkg;

  localparam int unsigned ADDR_W_DEF      = 11;
  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int unsigned TIMEOUT_CYC_DEF = 1024;

  localparam int unsigned BYTE_IDX_W = 2;

  localparam logic [BYTE_IDX_W-1:0] HDR_ADDR_LO = 2'd0;
  localparam logic [BYTE_IDX_W-1:0] HDR_ADDR_HI = 2'd1;
  localparam logic [BYTE_IDX_W-1:0] HDR_CNT_LO  = 2'd2;
  localparam logic [BYTE_IDX_W-1:0] HDR_CNT_HI  = 2'd3;
  localparam logic [BYTE_IDX_W-1:0] WORD_LAST   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_RUN,
    ST_ERR
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Loader bus: byte stream in (s_*), memory write port out (w_*), CPU control out.
//   master : the loader (accepts bytes, drives writes and CPU control)
//   slave  : the host / memory / CPU side
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              w_enable;
  logic [ADDR_W-1:0] w_adrs;
  logic [31:0]       w_instruction;
  logic              cpu_en;
  logic              load_done;
  logic              load_error;

  modport master (
    input  s_valid, s_data,
    output s_ready, w_enable, w_adrs, w_instruction, cpu_en, load_done, load_error
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, w_enable, w_adrs, w_instruction, cpu_en, load_done, load_error
  );

endinterface

// File: rtl/program_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled; flags expiry on the
// TIMEOUT_CYC-th consecutive cycle without a clear.
//   clk_i, reset_i : clock, synchronous active-high reset
//   en_i           : counting enabled (frame in progress)
//   clr_i          : byte accepted this cycle
//   expire_c_o     : combinational expiry flag
module program_loader_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_c;

  assign expire_c   = en_i && !clr_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign expire_c_o = expire_c;

  // Count only idle cycles inside a frame; any accept or leaving the frame restarts
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (!expire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader.
// Frame: SYNC | ADDR lo,hi | COUNT lo,hi | COUNT x 4 data bytes (LE) | CSUM.
// Writes each assembled word to memory, then enables the CPU once the frame's
// 8-bit checksum (all bytes after SYNC, CSUM included) sums to zero.
//   clk, reset : clock, synchronous active-high reset
//   bus        : program_loader_if.master (s_* byte stream, w_* write port,
//                cpu_en, load_done pulse, sticky load_error)
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  program_loader_if.master    bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e                  state_q, state_d;
  logic [BYTE_IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]              lo_q, lo_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CNT_W-1:0]        words_q, words_d;
  logic [23:0]             word_q, word_d;
  logic [7:0]              sum_q, sum_d;

  logic                    s_ready_q;
  logic                    w_enable_q, w_enable_d;
  logic [ADDR_W-1:0]       w_adrs_q, w_adrs_d;
  logic [31:0]             w_instr_q, w_instr_d;
  logic                    cpu_en_q, cpu_en_d;
  logic                    load_done_q, load_done_d;
  logic                    load_error_q, load_error_d;

  logic                    accept_c;
  logic                    active_c;
  logic                    expire_c;
  logic                    is_sync_c;
  logic [7:0]              sum_next_c;
  logic [15:0]             count_c;

  assign accept_c   = bus.s_valid & s_ready_q;
  assign active_c   = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign is_sync_c  = (bus.s_data == SYNC_BYTE);
  assign sum_next_c = sum_q + bus.s_data;
  assign count_c    = {bus.s_data, lo_q};

  program_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk_i      (clk),
    .reset_i    (reset),
    .en_i       (active_c),
    .clr_i      (accept_c),
    .expire_c_o (expire_c)
  );

  // Next state, byte assembly, checksum and write generation
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    addr_d      = addr_q;
    words_d     = words_q;
    word_d      = word_q;
    sum_d       = sum_q;
    w_enable_d  = 1'b0;
    w_adrs_d    = w_adrs_q;
    w_instr_d   = w_instr_q;
    load_done_d = 1'b0;

    if (expire_c) begin
      state_d = ST_ERR;
    end else if (accept_c) begin
      unique case (state_q)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (is_sync_c) begin
            state_d = ST_HDR;
            idx_d   = '0;
            sum_d   = '0;
          end
        end
        ST_HDR: begin
          sum_d = sum_next_c;
          idx_d = idx_q + BYTE_IDX_W'(1);
          unique case (idx_q)
            HDR_ADDR_LO, HDR_CNT_LO: lo_d   = bus.s_data;
            HDR_ADDR_HI:             addr_d = ADDR_W'({bus.s_data, lo_q});
            HDR_CNT_HI: begin
              // Full 16-bit count is checked so oversize frames are rejected
              if (count_c == 16'd0) begin
                state_d = ST_CSUM;
              end else if (32'(count_c) > (32'd1 << ADDR_W)) begin
                state_d = ST_ERR;
              end else begin
                state_d = ST_DATA;
                words_d = CNT_W'(count_c);
              end
            end
            default: ;
          endcase
        end
        ST_DATA: begin
          sum_d  = sum_next_c;
          idx_d  = idx_q + BYTE_IDX_W'(1);
          // Little-endian: earlier bytes shift down toward bit 0
          word_d = {bus.s_data, word_q[23:8]};
          if (idx_q == WORD_LAST) begin
            w_enable_d = 1'b1;
            w_adrs_d   = addr_q;
            w_instr_d  = {bus.s_data, word_q};
            addr_d     = addr_q + ADDR_W'(1);
            words_d    = words_q - CNT_W'(1);
            if (words_q == CNT_W'(1)) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (sum_next_c == 8'h00) begin
            state_d     = ST_RUN;
            load_done_d = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    cpu_en_d     = (state_d == ST_RUN);
    load_error_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      lo_q         <= '0;
      addr_q       <= '0;
      words_q      <= '0;
      word_q       <= '0;
      sum_q        <= '0;
      s_ready_q    <= 1'b0;
      w_enable_q   <= 1'b0;
      w_adrs_q     <= '0;
      w_instr_q    <= '0;
      cpu_en_q     <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lo_q         <= lo_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      word_q       <= word_d;
      sum_q        <= sum_d;
      s_ready_q    <= 1'b1;
      w_enable_q   <= w_enable_d;
      w_adrs_q     <= w_adrs_d;
      w_instr_q    <= w_instr_d;
      cpu_en_q     <= cpu_en_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign bus.s_ready       = s_ready_q;
  assign bus.w_enable      = w_enable_q;
  assign bus.w_adrs        = w_adrs_q;
  assign bus.w_instruction = w_instr_q;
  assign bus.cpu_en        = cpu_en_q;
  assign bus.load_done     = load_done_q;
  assign bus.load_error    = load_error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: frames are built from the framing rules,
// expected memory writes are queued, and a negedge monitor checks each write.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int unsigned AW = 11;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(AW)) bus();

  program_loader #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wr_t         exp_q[$];
  wr_t         e;
  logic [31:0] fw[$];
  logic [7:0]  fb[$];
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          done_seen = 0;
  int          done_exp  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.w_enable) begin
      check("wr_cpu_en_low", 32'(bus.cpu_en), 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got adrs %h data %h required no write",
                 bus.w_adrs, bus.w_instruction);
      end else begin
        e = exp_q.pop_front();
        check("wr_adrs", 32'(bus.w_adrs), 32'(e.a));
        check("wr_data", bus.w_instruction, e.d);
      end
    end
    if (bus.load_done) done_seen++;
  end

  // Reference model: serialise fw[] into a frame and predict its writes
  task automatic build_frame(input logic [15:0] addr, input logic [7:0] delta, input bit expect_wr);
    int         s;
    logic [15:0] cnt;
    wr_t        w;
    cnt = 16'(fw.size());
    fb.delete();
    fb.push_back(8'hA5);
    fb.push_back(addr[7:0]);
    fb.push_back(addr[15:8]);
    fb.push_back(cnt[7:0]);
    fb.push_back(cnt[15:8]);
    foreach (fw[i]) for (int k = 0; k < 4; k++) fb.push_back(8'(fw[i] >> (8 * k)));
    s = 0;
    for (int i = 1; i < fb.size(); i++) s += int'(fb[i]);
    fb.push_back(8'((256 - (s % 256)) + int'(delta)));
    if (expect_wr) begin
      foreach (fw[i]) begin
        w.a = AW'((int'(addr) + i) % (1 << AW));
        w.d = fw[i];
        exp_q.push_back(w);
      end
    end
  endtask

  // Called and returns at 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.s_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int gap_max);
    for (int i = lo; i <= hi; i++) send_byte(fb[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic post_check(input string tag, input bit cpu_exp, input bit err_exp);
    idle(2);
    check({tag, "_cpu_en"}, 32'(bus.cpu_en), 32'(cpu_exp));
    check({tag, "_load_error"}, 32'(bus.load_error), 32'(err_exp));
    check({tag, "_done_count"}, 32'(done_seen), 32'(done_exp));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] junk;
    logic [7:0] delta;
    int         nw;

    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    idle(3);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    check("rst_load_error", 32'(bus.load_error), 32'd0);
    check("rst_w_enable", 32'(bus.w_enable), 32'd0);
    reset = 1'b0;
    idle(1);
    check("s_ready_after_rst", 32'(bus.s_ready), 32'd1);

    // 1: basic two-word frame, back-to-back
    fw = '{32'h0000000d, 32'h0000000f};
    build_frame(16'h0004, 8'h00, 1'b1);
    check("t1_csum_byte", 32'(fb[fb.size()-1]), 32'h000000DE);
    send_range(0, fb.size() - 2, 0);
    check("t1_cpu_en_before_csum", 32'(bus.cpu_en), 32'd0);
    send_range(fb.size() - 1, fb.size() - 1, 0);
    check("t1_cpu_en_next", 32'(bus.cpu_en), 32'd1);
    check("t1_load_done_next", 32'(bus.load_done), 32'd1);
    done_exp++;
    post_check("t1", 1'b1, 1'b0);

    // 2: bad checksum (DF): writes still happen, error flagged
    build_frame(16'h0004, 8'h01, 1'b1);
    send_range(0, fb.size() - 1, 0);
    post_check("t2", 1'b0, 1'b1);

    // 4: zero-count frame
    fw.delete();
    build_frame(16'h0010, 8'h00, 1'b1);
    send_range(0, fb.size() - 1, 0);
    done_exp++;
    post_check("t4", 1'b1, 1'b0);

    // 5: address wrap 0x7FF -> 0x000
    fw = '{32'h11111111, 32'h22222222};
    build_frame(16'h07FF, 8'h00, 1'b1);
    send_range(0, fb.size() - 1, 0);
    done_exp++;
    post_check("t5", 1'b1, 1'b0);

    // SYNC during RUN drops cpu_en next cycle, then reloads
    fw = '{32'h0000000d, 32'h0000000f};
    build_frame(16'h0004, 8'h00, 1'b1);
    send_range(0, 0, 0);
    check("run_sync_cpu_en_drop", 32'(bus.cpu_en), 32'd0);
    send_range(1, fb.size() - 1, 0);
    done_exp++;
    post_check("run_reload", 1'b1, 1'b0);

    // Random gaps give identical writes
    build_frame(16'h0004, 8'h00, 1'b1);
    send_range(0, fb.size() - 1, 20);
    done_exp++;
    post_check("gaps", 1'b1, 1'b0);

    // Long (sub-timeout) stall mid-word is tolerated
    build_frame(16'h0004, 8'h00, 1'b1);
    send_range(0, 6, 0);
    idle(1000);
    send_range(7, fb.size() - 1, 0);
    done_exp++;
    post_check("stall_1000", 1'b1, 1'b0);

    // 3: stall past timeout after byte 7 -> ERR, trailing bytes ignored
    build_frame(16'h0004, 8'h00, 1'b0);
    send_range(0, 6, 0);
    idle(1100);
    check("t3_timeout_error", 32'(bus.load_error), 32'd1);
    send_range(7, fb.size() - 1, 0);
    post_check("t3_after", 1'b0, 1'b1);
    build_frame(16'h0004, 8'h00, 1'b1);
    send_range(0, fb.size() - 1, 0);
    done_exp++;
    post_check("t3_recover", 1'b1, 1'b0);

    // 6: reset mid-DATA: only the completed word is written
    fw = '{32'h01020304, 32'h05060708, 32'h090a0b0c};
    build_frame(16'h0100, 8'h00, 1'b0);
    e.a = AW'(11'h100);
    e.d = 32'h01020304;
    exp_q.push_back(e);
    send_range(0, 10, 0);
    reset = 1'b1;
    idle(1);
    check("t6_rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    check("t6_rst_s_ready", 32'(bus.s_ready), 32'd0);
    idle(1);
    reset = 1'b0;
    send_range(11, fb.size() - 1, 0);
    post_check("t6_after_rst", 1'b0, 1'b0);

    // Randomised frames with junk between them
    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, 0);
      end
      fw.delete();
      nw = int'($urandom_range(1, 5));
      for (int i = 0; i < nw; i++) fw.push_back($urandom);
      delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build_frame(16'($urandom), delta, 1'b1);
      send_range(0, fb.size() - 1, 3);
      if (delta == 8'h00) done_exp++;
      post_check("rand", delta == 8'h00, delta != 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
